div_rate_sched: RTL and testbench

Run-time rate scheduler for the board's divided clock. It produces `div_out`, a 50%-duty divided clock, plus a one-cycle `tick` strobe, both derived from `clk_50m`. Two requesters (front-panel logic and debug UART) share the divider through a round-robin req/ack arbiter. Each requester submits a new half-period count. An accepted value is staged and applied only at a half-period boundary, so `div_out` never produces a runt or stretched phase.

---
 rtl/div_rate_sched.sv | 188 ++++++++++++++++++
 tb/tb_div_rate_sched.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rate_sched.sv
// div_rate_sched
//   Run-time rate scheduler for the board's divided clock. A free-running
//   counter produces a 50%-duty clock (div_out) from clk_50m. It also produces
//   a one-cycle strobe (tick) in the cycle after each rising edge of div_out.
//   Two requesters share the divider through a round-robin req/ack arbiter.
//   A granted half-period count is staged. It takes effect only at a
//   half-period boundary, so no phase is ever cut short or stretched.
//
//   Optional feature: define DIV_RATE_STOP_EN to make a requested count of 0
//   stop the divider. The stop takes effect at a falling boundary, and a later
//   nonzero grant restarts the divider. Without the macro, 0 is clamped to
//   MIN_HALF.
//
// Parameters
//   CNT_W        counter / half-period width
//   DEFAULT_HALF half-period count after reset (half-period = value+1 cycles)
//   MIN_HALF     smallest legal nonzero half-period count
//
// Ports
//   clk_50m      system clock
//   rst_n        asynchronous active-low reset
//   req[1:0]     rate-change requests, held until the matching ack
//   half_a       requested count from requester 0
//   half_b       requested count from requester 1
//   ack[1:0]     one-cycle grant pulse; the value is captured on its rising edge
//   div_out      divided clock
//   tick         one-cycle pulse in the cycle after div_out rises
//   busy         a staged value is waiting for a boundary
//   active_half  half-period count currently in use
module div_rate_sched #(
    parameter int unsigned      CNT_W        = 24,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(12499999),
    parameter logic [CNT_W-1:0] MIN_HALF     = CNT_W'(1)
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] half_a,
    input  logic [CNT_W-1:0] half_b,
    output logic [1:0]       ack,
    output logic             div_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] active_half
);

`ifdef DIV_RATE_STOP_EN
    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_RUN, ST_PEND} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] staged_q, staged_d;
    logic             div_q, div_d;
    logic             div_dly_q, div_dly_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [1:0]       ack_q, ack_d;
    logic             pri_q, pri_d;      // requester favoured on a tie
    logic             boundary;
    logic             can_grant;
    logic             gsel;

    function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] v);
`ifdef DIV_RATE_STOP_EN
        if (v == '0) return '0;          // 0 is the stop request
`endif
        if (v < MIN_HALF) return MIN_HALF;
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        staged_d  = staged_q;
        div_d     = div_q;
        ack_d     = 2'b00;
        pri_d     = pri_q;
        gsel      = 1'b0;
        boundary  = (cnt_q >= active_q);

        // Counter, divided clock and staged-value apply
        case (state_q)
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    div_d = ~div_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PEND: begin
`ifdef DIV_RATE_STOP_EN
                // active_q is 0 only when leaving STOP: apply at once, no toggle,
                // so the first rise comes value+1 cycles later.
                if (active_q == '0) begin
                    cnt_d    = '0;
                    div_d    = 1'b0;
                    active_d = staged_q;
                    state_d  = (staged_q == '0) ? ST_STOP : ST_RUN;
                end else
`endif
                if (boundary) begin
                    cnt_d = '0;
`ifdef DIV_RATE_STOP_EN
                    if (staged_q == '0 && !div_q) begin
                        // Rising boundary: a stop must wait for the falling one.
                        div_d = 1'b1;
                    end else if (staged_q == '0) begin
                        div_d    = 1'b0;
                        active_d = '0;
                        state_d  = ST_STOP;
                    end else
`endif
                    begin
                        div_d    = ~div_q;
                        active_d = staged_q;
                        state_d  = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef DIV_RATE_STOP_EN
            ST_STOP: begin
                cnt_d = '0;
                div_d = 1'b0;
            end
`endif
            default: state_d = ST_RUN;
        endcase

        // Round-robin arbitration; never while a value is staged
`ifdef DIV_RATE_STOP_EN
        can_grant = (state_q == ST_RUN || state_q == ST_STOP) && (req != 2'b00);
`else
        can_grant = (state_q == ST_RUN) && (req != 2'b00);
`endif
        if (can_grant) begin
            gsel     = (req == 2'b11) ? pri_q : req[1];
            ack_d    = gsel ? 2'b10 : 2'b01;
            staged_d = clamp_half(gsel ? half_b : half_a);
            pri_d    = ~gsel;
            state_d  = ST_PEND;
        end

        busy_d    = (state_d == ST_PEND);
        div_dly_d = div_q;
        tick_d    = div_q & ~div_dly_q;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            active_q  <= DEFAULT_HALF;
            staged_q  <= '0;
            div_q     <= 1'b0;
            div_dly_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 2'b00;
            pri_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            staged_q  <= staged_d;
            div_q     <= div_d;
            div_dly_q <= div_dly_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            pri_q     <= pri_d;
        end
    end

    assign ack         = ack_q;
    assign div_out     = div_q;
    assign tick        = tick_q;
    assign busy        = busy_q;
    assign active_half = active_q;

endmodule

// File: tb/tb_div_rate_sched.sv
module tb_div_rate_sched;

    localparam int CW   = 8;
    localparam int DEF  = 3;
    localparam int MINH = 2;
`ifdef DIV_RATE_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic          clk_50m = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    req     = 2'b00;
    logic [CW-1:0] half_a  = '0;
    logic [CW-1:0] half_b  = '0;
    logic [1:0]    ack;
    logic          div_out;
    logic          tick;
    logic          busy;
    logic [CW-1:0] active_half;

    int n_checks = 0;
    int n_errors = 0;

    div_rate_sched #(
        .CNT_W       (CW),
        .DEFAULT_HALF(CW'(DEF)),
        .MIN_HALF    (CW'(MINH))
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .req        (req),
        .half_a     (half_a),
        .half_b     (half_b),
        .ack        (ack),
        .div_out    (div_out),
        .tick       (tick),
        .busy       (busy),
        .active_half(active_half)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int model_clamp(input int v);
        if (v == 0) return STOP_EN ? 0 : MINH;
        if (v < MINH) return MINH;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks the expected half-period of each phase, the
    // staged value, the arbitration pointer and the stop condition, and
    // checks every cycle against the DUT.
    // ------------------------------------------------------------------
    logic          r_rstn;
    logic [1:0]    r_req;
    logic [CW-1:0] r_a, r_b;
    logic          m_prev_div, m_prev2_div, m_pend, m_stopped, m_pri, m_pend_before, m_toggle;
    logic [1:0]    m_exp_ack;
    int            m_cnt, m_exp_half, m_active, m_staged;

    always begin
        @(posedge clk_50m);
        r_rstn = rst_n;
        r_req  = req;
        r_a    = half_a;
        r_b    = half_b;
        #1;
        if (!r_rstn) begin
            m_prev_div  = 1'b0;
            m_prev2_div = 1'b0;
            m_pend      = 1'b0;
            m_stopped   = 1'b0;
            m_pri       = 1'b0;
            m_cnt       = 1;
            m_active    = DEF;
            m_exp_half  = DEF;
            m_staged    = 0;
        end else begin
            m_toggle      = (div_out !== m_prev_div);
            m_pend_before = m_pend;

            n_checks++;
            if (tick !== (m_prev_div & ~m_prev2_div)) begin
                n_errors++;
                $display("FAIL tick_model: tick=%b required %b at %0t", tick, m_prev_div & ~m_prev2_div, $time);
            end

            if (m_stopped) begin
                n_checks++;
                if (div_out !== 1'b0 || tick !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stop_hold: div_out=%b tick=%b required 0/0 at %0t", div_out, tick, $time);
                end
                if (m_pend_before) begin
                    m_pend = 1'b0;
                    if (m_staged != 0) begin
                        m_stopped  = 1'b0;
                        m_active   = m_staged;
                        m_exp_half = m_staged;
                        m_cnt      = 1;
                    end
                end
            end else if (m_toggle) begin
                n_checks++;
                if (m_cnt != m_exp_half + 1) begin
                    n_errors++;
                    $display("FAIL phase_len: phase of %0d cycles, required %0d at %0t", m_cnt, m_exp_half + 1, $time);
                end
                if (m_pend_before) begin
                    if (STOP_EN && m_staged == 0) begin
                        if (div_out === 1'b0) begin
                            m_stopped = 1'b1;
                            m_pend    = 1'b0;
                            m_active  = 0;
                        end
                    end else begin
                        m_active = m_staged;
                        m_pend   = 1'b0;
                    end
                end
                m_exp_half = m_active;
                m_cnt      = 1;
            end else begin
                m_cnt++;
            end

            m_exp_ack = 2'b00;
            if (!m_pend_before && r_req != 2'b00)
                m_exp_ack = (r_req == 2'b11) ? (m_pri ? 2'b10 : 2'b01) : r_req;
            n_checks++;
            if (ack !== m_exp_ack) begin
                n_errors++;
                $display("FAIL grant_model: ack=%b required %b at %0t", ack, m_exp_ack, $time);
            end
            if (m_exp_ack != 2'b00) begin
                m_pend   = 1'b1;
                m_staged = model_clamp(m_exp_ack[1] ? int'(r_b) : int'(r_a));
                m_pri    = ~m_exp_ack[1];
            end

            n_checks++;
            if (busy !== m_pend) begin
                n_errors++;
                $display("FAIL busy_model: busy=%b required %b at %0t", busy, m_pend, $time);
            end
            n_checks++;
            if (int'(active_half) != m_active) begin
                n_errors++;
                $display("FAIL active_model: active_half=%0d required %0d at %0t", active_half, m_active, $time);
            end
            m_prev2_div = m_prev_div;
            m_prev_div  = div_out;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic apply_reset();
        @(negedge clk_50m);
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    // Length in cycles of the next complete phase of div_out; -1 on timeout.
    task automatic measure_phase(output int len);
        logic d;
        int   k;
        d   = div_out;
        len = -1;
        k   = 0;
        while (div_out === d && k < 100) begin
            @(negedge clk_50m);
            k++;
        end
        if (k < 100) begin
            d = div_out;
            k = 0;
            while (k < 100) begin
                @(negedge clk_50m);
                k++;
                if (div_out !== d) break;
            end
            if (k < 100) len = k;
        end
    endtask

    // Issue one request, drop it on ack, wait for the apply.
    task automatic do_change(input int idx, input int val, output logic [1:0] ack_got, output int apply_cyc);
        @(negedge clk_50m);
        if (idx == 0) begin half_a = CW'(val); req[0] = 1'b1; end
        else          begin half_b = CW'(val); req[1] = 1'b1; end
        ack_got = 2'b00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_50m);
            if (ack != 2'b00) begin ack_got = ack; break; end
        end
        req       = 2'b00;
        apply_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin apply_cyc = k; break; end
            @(negedge clk_50m);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk_50m);
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        n_checks++;
        if (ack !== 2'b00 || div_out !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || int'(active_half) != DEF) begin
            n_errors++;
            $display("FAIL reset_values: ack=%b div=%b tick=%b busy=%b active=%0d required 00/0/0/0/%0d",
                     ack, div_out, tick, busy, active_half, DEF);
        end
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    task automatic test_default_rate();
        int  n;
        int  p;
        logic ack_seen;
        n = 0;
        ack_seen = 1'b0;
        while (div_out !== 1'b1 && n < 50) begin
            @(negedge clk_50m);
            n++;
            if (ack != 2'b00) ack_seen = 1'b1;
        end
        n_checks++;
        if (n != DEF + 1) begin
            n_errors++;
            $display("FAIL first_rise: after %0d cycles, required %0d", n, DEF + 1);
        end
        @(negedge clk_50m);
        n_checks++;
        if (tick !== 1'b1) begin
            n_errors++;
            $display("FAIL tick_after_rise: tick=%b required 1", tick);
        end
        @(negedge clk_50m);
        n_checks++;
        if (tick !== 1'b0) begin
            n_errors++;
            $display("FAIL tick_width: tick=%b required 0", tick);
        end
        p = 2;
        while (!(div_out === 1'b1 && p > 2 && m_prev2_div === 1'b0) && p < 50) begin
            @(negedge clk_50m);
            p++;
            if (ack != 2'b00) ack_seen = 1'b1;
            if (div_out === 1'b1 && p > 4) break;
        end
        n_checks++;
        if (p != 2 * (DEF + 1)) begin
            n_errors++;
            $display("FAIL period: period %0d cycles, required %0d", p, 2 * (DEF + 1));
        end
        n_checks++;
        if (ack_seen) begin
            n_errors++;
            $display("FAIL idle_ack: ack=1 seen, required 00");
        end
    endtask

    task automatic test_single_change();
        int k;
        int len;
        @(negedge clk_50m);
        half_a = CW'(5);
        req    = 2'b01;
        @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b01 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ack: ack=%b busy=%b required 01/1", ack, busy);
        end
        req = 2'b00;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk_50m);
            k++;
        end
        n_checks++;
        if (k > DEF + 1 || int'(active_half) != 5) begin
            n_errors++;
            $display("FAIL single_apply: apply after %0d cycles active=%0d, required <=%0d and 5", k, active_half, DEF + 1);
        end
        measure_phase(len);
        n_checks++;
        if (len != 6) begin
            n_errors++;
            $display("FAIL single_phase: phase %0d cycles, required 6", len);
        end
    endtask

    task automatic test_contention();
        int k;
        int len;
        apply_reset();
        half_a = CW'(2);
        half_b = CW'(7);
        req    = 2'b11;
        @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b01) begin
            n_errors++;
            $display("FAIL contention_first: ack=%b required 01", ack);
        end
        req = 2'b10;
        k = 0;
        while (ack !== 2'b10 && k < 30) begin
            @(negedge clk_50m);
            k++;
        end
        n_checks++;
        if (ack !== 2'b10 || int'(active_half) != 2) begin
            n_errors++;
            $display("FAIL contention_second: ack=%b active=%0d required 10 and 2", ack, active_half);
        end
        req = 2'b00;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk_50m);
            k++;
        end
        n_checks++;
        if (int'(active_half) != 7) begin
            n_errors++;
            $display("FAIL contention_apply: active=%0d required 7", active_half);
        end
        measure_phase(len);
        n_checks++;
        if (len != 8) begin
            n_errors++;
            $display("FAIL contention_phase: phase %0d cycles, required 8", len);
        end
    endtask

    task automatic test_clamp();
        logic [1:0] a;
        int         c;
        do_change(1, 1, a, c);
        n_checks++;
        if (a !== 2'b10 || c < 0 || int'(active_half) != MINH) begin
            n_errors++;
            $display("FAIL clamp_min: ack=%b apply=%0d active=%0d required 10 and %0d", a, c, active_half, MINH);
        end
        do_change(0, 6, a, c);
        n_checks++;
        if (a !== 2'b01 || int'(active_half) != 6) begin
            n_errors++;
            $display("FAIL clamp_pass: ack=%b active=%0d required 01 and 6", a, active_half);
        end
`ifndef DIV_RATE_STOP_EN
        do_change(0, 0, a, c);
        n_checks++;
        if (a !== 2'b01 || int'(active_half) != MINH) begin
            n_errors++;
            $display("FAIL clamp_zero: ack=%b active=%0d required 01 and %0d", a, active_half, MINH);
        end
`endif
    endtask

    task automatic test_reset_mid_pend();
        @(negedge clk_50m);
        half_a = CW'(9);
        req    = 2'b01;
        @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b01 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midpend_setup: ack=%b busy=%b required 01/1", ack, busy);
        end
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b00 || div_out !== 1'b0 || tick !== 1'b0 || busy !== 1'b0 || int'(active_half) != DEF) begin
            n_errors++;
            $display("FAIL midpend_reset: ack=%b div=%b tick=%b busy=%b active=%0d required 00/0/0/0/%0d",
                     ack, div_out, tick, busy, active_half, DEF);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk_50m);
        n_checks++;
        if (busy !== 1'b0 || int'(active_half) != DEF) begin
            n_errors++;
            $display("FAIL midpend_discard: busy=%b active=%0d required 0 and %0d", busy, active_half, DEF);
        end
    endtask

`ifdef DIV_RATE_STOP_EN
    task automatic test_stop();
        int   k;
        logic pd;
        logic ok;
        apply_reset();
        pd = div_out;
        k  = 0;
        while (!(pd === 1'b1 && div_out === 1'b0) && k < 40) begin
            pd = div_out;
            @(negedge clk_50m);
            k++;
        end
        half_a = '0;
        req    = 2'b01;
        @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b01 || div_out !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_grant: ack=%b div=%b required 01/0", ack, div_out);
        end
        req = 2'b00;
        pd  = div_out;
        k   = 0;
        while (!(pd === 1'b1 && div_out === 1'b0) && k < 40) begin
            pd = div_out;
            @(negedge clk_50m);
            k++;
        end
        n_checks++;
        if (k >= 40 || busy !== 1'b0 || int'(active_half) != 0) begin
            n_errors++;
            $display("FAIL stop_enter: wait=%0d busy=%b active=%0d required fall, 0, 0", k, busy, active_half);
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50m);
            if (div_out !== 1'b0 || tick !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL stop_idle: div_out/tick activity seen, required none");
        end
        half_b = CW'(3);
        req    = 2'b10;
        @(negedge clk_50m);
        n_checks++;
        if (ack !== 2'b10) begin
            n_errors++;
            $display("FAIL restart_grant: ack=%b required 10", ack);
        end
        req = 2'b00;
        @(negedge clk_50m);
        n_checks++;
        if (busy !== 1'b0 || int'(active_half) != 3 || div_out !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_apply: busy=%b active=%0d div=%b required 0/3/0", busy, active_half, div_out);
        end
        k = 0;
        while (div_out !== 1'b1 && k < 40) begin
            @(negedge clk_50m);
            k++;
        end
        n_checks++;
        if (k != 4) begin
            n_errors++;
            $display("FAIL restart_rise: rise after %0d cycles, required 4", k);
        end
    endtask
`endif

    task automatic test_random();
        int n_acks;
        apply_reset();
        n_acks = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_50m);
            if (ack != 2'b00) n_acks++;
            for (int r = 0; r < 2; r++) begin
                if (req[r] && ack[r]) begin
                    req[r] = 1'b0;
                end else if (!req[r] && ($urandom % 5) == 0) begin
                    if (r == 0) half_a = CW'($urandom_range(9, 0));
                    else        half_b = CW'($urandom_range(9, 0));
                    req[r] = 1'b1;
                end
            end
        end
        @(negedge clk_50m);
        req = 2'b00;
        repeat (30) @(negedge clk_50m);
        n_checks++;
        if (n_acks < 5) begin
            n_errors++;
            $display("FAIL random_activity: %0d grants, required at least 5", n_acks);
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_single_change();
        test_contention();
        test_clamp();
        test_reset_mid_pend();
`ifdef DIV_RATE_STOP_EN
        test_stop();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
